// File: rtl/z_store_stream_sink_pkg.sv
// z_store_stream_sink_pkg
// Shared types and constants for the Z store stream sink.
//   hci_streamer_ctrl_t : store config issued by the Z data scheduler
//   z_sink_state_t      : sink FSM states
//   Z_SINK_BW / Z_SINK_ADDR_W : default beat width and byte-address width
//   Z_SINK_BE_ALL       : full-word byte-enable mask at the default width
package z_store_stream_sink_pkg;

  localparam int unsigned Z_SINK_BW     = 128;
  localparam int unsigned Z_SINK_ADDR_W = 32;

  localparam logic [Z_SINK_BW/8-1:0] Z_SINK_BE_ALL = '1;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] tot_len;
    logic [31:0] d0_len;
    logic [31:0] d0_stride;
    logic [31:0] d1_stride;
    logic [3:0]  dim_enable_1h;
  } hci_streamer_addressgen_ctrl_t;

  typedef struct packed {
    logic                          req_start;
    hci_streamer_addressgen_ctrl_t addressgen_ctrl;
  } hci_streamer_ctrl_t;

  typedef enum logic {
    Z_SINK_IDLE = 1'b0,
    Z_SINK_RUN  = 1'b1
  } z_sink_state_t;

endpackage

// File: rtl/z_store_stream_sink_if.sv
// z_store_stream_sink_if
// Bundles the Z result stream and the TCDM write port of the sink.
// Signal names are written from the sink's point of view.
//   data_i / data_valid_i / data_ready_o : Z result beat stream
//   mem_req_o / mem_gnt_i                : TCDM request/grant
//   mem_add_o / mem_wen_o / mem_be_o / mem_data_o : TCDM write payload
// Modports: master = the sink, slave = stream source + memory side.
interface z_store_stream_sink_if
  import z_store_stream_sink_pkg::*;
#(
  parameter int unsigned BW     = Z_SINK_BW,
  parameter int unsigned ADDR_W = Z_SINK_ADDR_W
) ();

  logic [BW-1:0]     data_i;
  logic              data_valid_i;
  logic              data_ready_o;
  logic              mem_req_o;
  logic              mem_gnt_i;
  logic [ADDR_W-1:0] mem_add_o;
  logic              mem_wen_o;
  logic [BW/8-1:0]   mem_be_o;
  logic [BW-1:0]     mem_data_o;

  modport master (
    input  data_i, data_valid_i, mem_gnt_i,
    output data_ready_o, mem_req_o, mem_add_o, mem_wen_o, mem_be_o, mem_data_o
  );

  modport slave (
    output data_i, data_valid_i, mem_gnt_i,
    input  data_ready_o, mem_req_o, mem_add_o, mem_wen_o, mem_be_o, mem_data_o
  );

endinterface

// File: rtl/z_store_stream_sink_addr_counter.sv
// z_sink_addr_counter
// Beat counter and 1D/2D address-offset walker for the Z store sink.
// Ports:
//   clk_i, rst_ni      : clock, async active-low reset
//   clear_i, load_i    : either one zeroes all counters
//   step_i             : advance by one beat
//   tot_len_i, d0_len_i, d0_stride_i, d1_stride_i, dim1_en_i : latched config
//   offset_o           : current byte offset from the base address
//   last_o             : current beat is the final one of the block
module z_sink_addr_counter
  import z_store_stream_sink_pkg::*;
#(
  parameter int unsigned ADDR_W = Z_SINK_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [31:0]       tot_len_i,
  input  logic [31:0]       d0_len_i,
  input  logic [ADDR_W-1:0] d0_stride_i,
  input  logic [ADDR_W-1:0] d1_stride_i,
  input  logic              dim1_en_i,
  output logic [ADDR_W-1:0] offset_o,
  output logic              last_o
);

  logic [31:0]       beat_q, beat_d;
  logic [31:0]       d0_idx_q, d0_idx_d;
  logic [ADDR_W-1:0] d0_off_q, d0_off_d;
  logic [ADDR_W-1:0] d1_off_q, d1_off_d;

  // d0_off tracks d0_idx*d0_stride by repeated addition. In 2D mode the
  // inner dimension wraps after d0_len beats and the outer offset steps.
  // All sums wrap modulo 2^ADDR_W on purpose.
  always_comb begin
    beat_d   = beat_q;
    d0_idx_d = d0_idx_q;
    d0_off_d = d0_off_q;
    d1_off_d = d1_off_q;
    if (clear_i || load_i) begin
      beat_d   = '0;
      d0_idx_d = '0;
      d0_off_d = '0;
      d1_off_d = '0;
    end else if (step_i) begin
      beat_d = beat_q + 32'd1;
      if (dim1_en_i && (d0_idx_q == d0_len_i - 32'd1)) begin
        d0_idx_d = '0;
        d0_off_d = '0;
        d1_off_d = d1_off_q + d1_stride_i;
      end else begin
        d0_idx_d = d0_idx_q + 32'd1;
        d0_off_d = d0_off_q + d0_stride_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q   <= '0;
      d0_idx_q <= '0;
      d0_off_q <= '0;
      d1_off_q <= '0;
    end else begin
      beat_q   <= beat_d;
      d0_idx_q <= d0_idx_d;
      d0_off_q <= d0_off_d;
      d1_off_q <= d1_off_d;
    end
  end

  assign offset_o = d0_off_q + d1_off_q;
  assign last_o   = (beat_q == tot_len_i - 32'd1);

endmodule

// File: rtl/z_store_stream_sink.sv
// z_store_stream_sink
// Write-side consumer of the Z scheduler's store configs. On req_start it
// latches the address pattern, then pairs each Z result beat with the next
// address and issues one TCDM write per beat. done_o pulses once the block
// is stored and feeds the scheduler's proceed input.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : synchronous soft clear / abort
//   ctrl_i        : store config, sampled only while req_start is high
//   bus (master)  : Z result stream in, TCDM write port out
//   busy_o        : block in progress
//   done_o        : one-cycle pulse after the final beat's grant
//   ctrl_err_o    : sticky, req_start seen while busy
module z_store_stream_sink
  import z_store_stream_sink_pkg::*;
#(
  parameter int unsigned BW     = Z_SINK_BW,
  parameter int unsigned ADDR_W = Z_SINK_ADDR_W
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  hci_streamer_ctrl_t           ctrl_i,
  z_store_stream_sink_if.master        bus,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         ctrl_err_o
);

  z_sink_state_t     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       tot_len_q, tot_len_d;
  logic [31:0]       d0_len_q, d0_len_d;
  logic [ADDR_W-1:0] d0_stride_q, d0_stride_d;
  logic [ADDR_W-1:0] d1_stride_q, d1_stride_d;
  logic              dim1_en_q, dim1_en_d;
  logic              done_q, done_d;
  logic              ctrl_err_q, ctrl_err_d;

  logic              cnt_load;
  logic              cnt_step;
  logic [ADDR_W-1:0] offset;
  logic              last_beat;
  logic              beat_fire;
  logic              running;

  // Only the first outer dimension is supported; higher enables are dropped.
  logic unused_dim_hi;
  assign unused_dim_hi = ^ctrl_i.addressgen_ctrl.dim_enable_1h[3:1];

  assign running   = (state_q == Z_SINK_RUN);
  assign beat_fire = running && bus.data_valid_i && bus.mem_gnt_i;

  // A zero-length block never enters RUN but still reports done so the
  // scheduler keeps moving. A start arriving while done_o is high is taken
  // normally because the FSM is already back in IDLE.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    tot_len_d   = tot_len_q;
    d0_len_d    = d0_len_q;
    d0_stride_d = d0_stride_q;
    d1_stride_d = d1_stride_q;
    dim1_en_d   = dim1_en_q;
    done_d      = 1'b0;
    ctrl_err_d  = ctrl_err_q;
    cnt_load    = 1'b0;
    cnt_step    = 1'b0;
    if (clear_i) begin
      state_d     = Z_SINK_IDLE;
      base_d      = '0;
      tot_len_d   = '0;
      d0_len_d    = '0;
      d0_stride_d = '0;
      d1_stride_d = '0;
      dim1_en_d   = 1'b0;
      ctrl_err_d  = 1'b0;
    end else begin
      case (state_q)
        Z_SINK_IDLE: begin
          if (ctrl_i.req_start) begin
            cnt_load    = 1'b1;
            base_d      = ctrl_i.addressgen_ctrl.base_addr[ADDR_W-1:0];
            tot_len_d   = ctrl_i.addressgen_ctrl.tot_len;
            d0_len_d    = ctrl_i.addressgen_ctrl.d0_len;
            d0_stride_d = ctrl_i.addressgen_ctrl.d0_stride[ADDR_W-1:0];
            d1_stride_d = ctrl_i.addressgen_ctrl.d1_stride[ADDR_W-1:0];
            dim1_en_d   = ctrl_i.addressgen_ctrl.dim_enable_1h[0];
            if (ctrl_i.addressgen_ctrl.tot_len == 32'd0) begin
              done_d = 1'b1;
            end else begin
              state_d = Z_SINK_RUN;
            end
          end
        end
        Z_SINK_RUN: begin
          if (ctrl_i.req_start) begin
            ctrl_err_d = 1'b1;
          end
          if (beat_fire) begin
            cnt_step = 1'b1;
            if (last_beat) begin
              state_d = Z_SINK_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = Z_SINK_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= Z_SINK_IDLE;
      base_q      <= '0;
      tot_len_q   <= '0;
      d0_len_q    <= '0;
      d0_stride_q <= '0;
      d1_stride_q <= '0;
      dim1_en_q   <= 1'b0;
      done_q      <= 1'b0;
      ctrl_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      tot_len_q   <= tot_len_d;
      d0_len_q    <= d0_len_d;
      d0_stride_q <= d0_stride_d;
      d1_stride_q <= d1_stride_d;
      dim1_en_q   <= dim1_en_d;
      done_q      <= done_d;
      ctrl_err_q  <= ctrl_err_d;
    end
  end

  z_sink_addr_counter #(
    .ADDR_W (ADDR_W)
  ) i_addr_counter (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .load_i      (cnt_load),
    .step_i      (cnt_step),
    .tot_len_i   (tot_len_q),
    .d0_len_i    (d0_len_q),
    .d0_stride_i (d0_stride_q),
    .d1_stride_i (d1_stride_q),
    .dim1_en_i   (dim1_en_q),
    .offset_o    (offset),
    .last_o      (last_beat)
  );

  // Data and address go straight to memory; upstream holds data_i stable
  // while stalled, so the request payload stays stable until grant.
  assign bus.mem_req_o    = running && bus.data_valid_i;
  assign bus.data_ready_o = beat_fire;
  assign bus.mem_add_o    = base_q + offset;
  assign bus.mem_wen_o    = 1'b0;
  assign bus.mem_be_o     = '1;
  assign bus.mem_data_o   = bus.data_i;

  assign busy_o     = running;
  assign done_o     = done_q;
  assign ctrl_err_o = ctrl_err_q;

endmodule

// File: tb/tb_z_store_stream_sink.sv
// tb_z_store_stream_sink
// Directed bench for z_store_stream_sink: single beat, grant stall,
// 2D walk, zero-length block, mid-run start / clear abort, and a
// back-to-back block with address wrap-around.
module tb_z_store_stream_sink;
  import z_store_stream_sink_pkg::*;

  localparam int unsigned BW     = 128;
  localparam int unsigned ADDR_W = 32;

  logic               clk_i;
  logic               rst_ni;
  logic               clear_i;
  hci_streamer_ctrl_t ctrl_i;
  logic               busy_o;
  logic               done_o;
  logic               ctrl_err_o;

  int checks    = 0;
  int errors    = 0;
  int write_cnt = 0;
  int wc_start;

  z_store_stream_sink_if #(.BW(BW), .ADDR_W(ADDR_W)) bus ();

  z_store_stream_sink #(.BW(BW), .ADDR_W(ADDR_W)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .ctrl_i     (ctrl_i),
    .bus        (bus.master),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .ctrl_err_o (ctrl_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Counts completed TCDM writes seen on the bus.
  always @(posedge clk_i) begin
    if (bus.mem_req_o && bus.mem_gnt_i) write_cnt <= write_cnt + 1;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a start for one cycle; returns 1 time unit after the sampling edge.
  task automatic start_block(input logic [31:0] base, input logic [31:0] tot,
                             input logic [31:0] d0_len, input logic [31:0] d0_stride,
                             input logic [31:0] d1_stride, input logic [3:0] dim);
    ctrl_i.req_start                     = 1'b1;
    ctrl_i.addressgen_ctrl.base_addr     = base;
    ctrl_i.addressgen_ctrl.tot_len       = tot;
    ctrl_i.addressgen_ctrl.d0_len        = d0_len;
    ctrl_i.addressgen_ctrl.d0_stride     = d0_stride;
    ctrl_i.addressgen_ctrl.d1_stride     = d1_stride;
    ctrl_i.addressgen_ctrl.dim_enable_1h = dim;
    next_cycle();
    ctrl_i.req_start = 1'b0;
  endtask

  // Offers one beat with grant high, checks the request, then clocks it.
  task automatic do_beat(input string tag, input logic [31:0] exp_addr, input logic [127:0] beat);
    bus.data_i       = beat;
    bus.data_valid_i = 1'b1;
    bus.mem_gnt_i    = 1'b1;
    #1;
    check_bit({tag, "_req"}, bus.mem_req_o, 1'b1);
    check_bit({tag, "_ready"}, bus.data_ready_o, 1'b1);
    check_word({tag, "_addr"}, 128'(bus.mem_add_o), 128'(exp_addr));
    check_word({tag, "_data"}, bus.mem_data_o, beat);
    next_cycle();
  endtask

  initial begin
    rst_ni           = 1'b0;
    clear_i          = 1'b0;
    ctrl_i           = '0;
    bus.data_i       = '0;
    bus.data_valid_i = 1'b1;
    bus.mem_gnt_i    = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_bit("rst_busy", busy_o, 1'b0);
    check_bit("rst_done", done_o, 1'b0);
    check_bit("rst_err", ctrl_err_o, 1'b0);
    check_bit("rst_req", bus.mem_req_o, 1'b0);
    check_bit("rst_ready", bus.data_ready_o, 1'b0);
    check_bit("rst_wen", bus.mem_wen_o, 1'b0);
    check_word("rst_be", 128'(bus.mem_be_o), 128'h0000_FFFF);
    rst_ni = 1'b1;
    bus.data_valid_i = 1'b0;
    bus.mem_gnt_i    = 1'b0;
    next_cycle();

    // 1: single beat
    $display("[TB] test 1: single beat");
    start_block(32'h1000, 32'd1, 32'd1, 32'd16, 32'd0, 4'b0000);
    check_bit("t1_busy", busy_o, 1'b1);
    check_bit("t1_req_idle_data", bus.mem_req_o, 1'b0);
    do_beat("t1_b0", 32'h1000, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666);
    bus.data_valid_i = 1'b0;
    check_bit("t1_done", done_o, 1'b1);
    check_bit("t1_busy_after", busy_o, 1'b0);
    next_cycle();
    check_bit("t1_done_pulse", done_o, 1'b0);

    // 2: linear, grant stalled three cycles on beat 2
    $display("[TB] test 2: grant stall");
    start_block(32'h1000, 32'd4, 32'd4, 32'd16, 32'd0, 4'b0000);
    wc_start = write_cnt;
    do_beat("t2_b0", 32'h1000, 128'h20);
    do_beat("t2_b1", 32'h1010, 128'h21);
    bus.data_i       = 128'hDEAD_BEEF_0000_0022;
    bus.data_valid_i = 1'b1;
    bus.mem_gnt_i    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_bit("t2_stall_req", bus.mem_req_o, 1'b1);
      check_bit("t2_stall_ready", bus.data_ready_o, 1'b0);
      check_word("t2_stall_addr", 128'(bus.mem_add_o), 128'h1020);
      check_word("t2_stall_data", bus.mem_data_o, 128'hDEAD_BEEF_0000_0022);
      check_bit("t2_stall_done", done_o, 1'b0);
      next_cycle();
    end
    do_beat("t2_b2", 32'h1020, 128'hDEAD_BEEF_0000_0022);
    do_beat("t2_b3", 32'h1030, 128'h23);
    bus.data_valid_i = 1'b0;
    check_bit("t2_done", done_o, 1'b1);
    check_word("t2_writes", 128'(write_cnt - wc_start), 128'd4);
    next_cycle();

    // 3: 2D walk
    $display("[TB] test 3: 2D pattern");
    start_block(32'h0, 32'd4, 32'd2, 32'd16, 32'h100, 4'b0001);
    do_beat("t3_b0", 32'h000, 128'h30);
    do_beat("t3_b1", 32'h010, 128'h31);
    do_beat("t3_b2", 32'h100, 128'h32);
    do_beat("t3_b3", 32'h110, 128'h33);
    bus.data_valid_i = 1'b0;
    check_bit("t3_done", done_o, 1'b1);
    next_cycle();

    // 4: zero-length block
    $display("[TB] test 4: zero length");
    bus.data_valid_i = 1'b1;
    bus.mem_gnt_i    = 1'b1;
    start_block(32'h4000, 32'd0, 32'd0, 32'd16, 32'd0, 4'b0000);
    check_bit("t4_done", done_o, 1'b1);
    check_bit("t4_busy", busy_o, 1'b0);
    check_bit("t4_req", bus.mem_req_o, 1'b0);
    next_cycle();
    check_bit("t4_done_pulse", done_o, 1'b0);
    check_bit("t4_req_after", bus.mem_req_o, 1'b0);
    bus.data_valid_i = 1'b0;

    // 5: start while running, then clear abort, then fresh block
    $display("[TB] test 5: ctrl error and clear");
    start_block(32'h2000, 32'd4, 32'd4, 32'd16, 32'd0, 4'b0000);
    ctrl_i.req_start                 = 1'b1;
    ctrl_i.addressgen_ctrl.base_addr = 32'h9000;
    do_beat("t5_b0", 32'h2000, 128'h50);
    ctrl_i.req_start = 1'b0;
    check_bit("t5_err", ctrl_err_o, 1'b1);
    check_bit("t5_busy", busy_o, 1'b1);
    do_beat("t5_b1", 32'h2010, 128'h51);
    clear_i          = 1'b1;
    bus.data_valid_i = 1'b1;
    bus.mem_gnt_i    = 1'b0;
    #1;
    check_bit("t5_req_clear_cycle", bus.mem_req_o, 1'b1);
    next_cycle();
    clear_i = 1'b0;
    check_bit("t5_req_cleared", bus.mem_req_o, 1'b0);
    check_bit("t5_busy_cleared", busy_o, 1'b0);
    check_bit("t5_err_cleared", ctrl_err_o, 1'b0);
    check_bit("t5_no_done", done_o, 1'b0);
    bus.data_valid_i = 1'b0;
    next_cycle();
    check_bit("t5_no_done_late", done_o, 1'b0);
    start_block(32'h3000, 32'd2, 32'd2, 32'd4, 32'd0, 4'b0000);
    do_beat("t5_f0", 32'h3000, 128'h58);
    do_beat("t5_f1", 32'h3004, 128'h59);
    bus.data_valid_i = 1'b0;
    check_bit("t5_fresh_done", done_o, 1'b1);
    check_bit("t5_fresh_err", ctrl_err_o, 1'b0);
    next_cycle();

    // 6: back-to-back start on the done cycle, address wraps
    $display("[TB] test 6: back-to-back with wrap");
    start_block(32'h5000, 32'd1, 32'd1, 32'd16, 32'd0, 4'b0000);
    do_beat("t6_a0", 32'h5000, 128'h60);
    bus.data_valid_i = 1'b0;
    check_bit("t6_done_a", done_o, 1'b1);
    start_block(32'hFFFF_FFF0, 32'd2, 32'd2, 32'd16, 32'd0, 4'b0000);
    check_bit("t6_busy_b", busy_o, 1'b1);
    check_bit("t6_done_b_clear", done_o, 1'b0);
    check_bit("t6_err_b", ctrl_err_o, 1'b0);
    do_beat("t6_b0", 32'hFFFF_FFF0, 128'h61);
    do_beat("t6_b1", 32'h0000_0000, 128'h62);
    bus.data_valid_i = 1'b0;
    check_bit("t6_done_b", done_o, 1'b1);
    next_cycle();
    check_bit("t6_done_b_pulse", done_o, 1'b0);
    check_bit("t6_busy_end", busy_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
